// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared opcode constants and hazard/forwarding enums for the RV32I core
package core_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        FLUSH = 2'd3
    } hz_state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

endpackage

// File: rtl/forward_unit.sv
// rtl/forward_unit.sv - EX operand forwarding selects from the MEM and WB destinations
module forward_unit
    import core_pkg::*;
(
    input  logic [4:0] ex_rs1,
    input  logic [4:0] ex_rs2,
    input  logic [4:0] mem_rd,
    input  logic       mem_reg_write,
    input  logic       mem_is_load,
    input  logic [4:0] wb_rd,
    input  logic       wb_reg_write,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    // MEM is younger so it wins; a load in MEM has no data yet and must fall back to WB
    function automatic fwd_sel_t pick(input logic [4:0] rs,
                                      input logic [4:0] m_rd, input logic m_we, input logic m_ld,
                                      input logic [4:0] w_rd, input logic w_we);
        fwd_sel_t sel;
        sel = FWD_RF;
        if (m_we && (m_rd != 5'd0) && !m_ld && (m_rd == rs))
            sel = FWD_MEM;
        else if (w_we && (w_rd != 5'd0) && (w_rd == rs))
            sel = FWD_WB;
        return sel;
    endfunction

    always_comb begin
        fwd_a = pick(ex_rs1, mem_rd, mem_reg_write, mem_is_load, wb_rd, wb_reg_write);
        fwd_b = pick(ex_rs2, mem_rd, mem_reg_write, mem_is_load, wb_rd, wb_reg_write);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use stall, redirect/flush sequencing and forwarding for the EX stage
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int FILL_CYCLES  = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [6:0]  ex_opcode,
    input  logic [4:0]  ex_rd,
    input  logic [4:0]  ex_rs1,
    input  logic [4:0]  ex_rs2,
    input  logic        ex_reg_write,
    input  logic [4:0]  mem_rd,
    input  logic [4:0]  wb_rd,
    input  logic        mem_reg_write,
    input  logic        wb_reg_write,
    input  logic        mem_is_load,
    input  logic [31:0] pc_if,
    input  logic        alu_pc_replace,
    input  logic        alu_pc_JALR,
    input  logic [31:0] alu_pc_new,
    output logic        pc_replace_old,
    output logic        flag_old,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        stall_pc,
    output logic        stall_if_id,
    output logic        bubble_id_ex,
    output logic        flush_if_id,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b
);

    localparam logic [7:0] FILL_INIT  = 8'(FILL_CYCLES - 1);
    localparam logic [7:0] FLUSH_INIT = 8'(FLUSH_CYCLES - 1);

    hz_state_t  state, state_d;
    logic [7:0] cnt, cnt_d;
    logic       load_use;
    logic [1:0] fu_a, fu_b;

    assign load_use = (ex_opcode == OP_LOAD) && ex_reg_write && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= FILL;
            cnt            <= FILL_INIT;
            pc_replace_old <= 1'b0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            pc_replace_old <= redirect_valid;
        end
    end

    always_comb begin
        state_d        = state;
        cnt_d          = cnt;
        flag_old       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        stall_pc       = 1'b0;
        stall_if_id    = 1'b0;
        bubble_id_ex   = 1'b0;
        flush_if_id    = 1'b0;
        case (state)
            FILL: begin
                if (cnt == 8'd0) state_d = RUN;
                else             cnt_d   = cnt - 8'd1;
            end
            RUN, STALL: begin
                flag_old = 1'b1;
                state_d  = RUN;
                if (alu_pc_replace) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = alu_pc_JALR ? alu_pc_new : pc_if + alu_pc_new;
                    flush_if_id    = 1'b1;
                    state_d        = FLUSH;
                    cnt_d          = FLUSH_INIT;
                end else if ((state == RUN) && load_use) begin
                    stall_pc     = 1'b1;
                    stall_if_id  = 1'b1;
                    bubble_id_ex = 1'b1;
                    state_d      = STALL;
                end
            end
            FLUSH: begin
                flush_if_id = 1'b1;
                if (cnt == 8'd0) state_d = RUN;
                else             cnt_d   = cnt - 8'd1;
            end
            default: state_d = FILL;
        endcase
        // While reset is held every control output reads as idle
        if (reset) begin
            flag_old       = 1'b0;
            redirect_valid = 1'b0;
            redirect_pc    = 32'd0;
            stall_pc       = 1'b0;
            stall_if_id    = 1'b0;
            bubble_id_ex   = 1'b0;
            flush_if_id    = 1'b0;
        end
    end

    forward_unit u_forward (
        .ex_rs1        (ex_rs1),
        .ex_rs2        (ex_rs2),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .mem_is_load   (mem_is_load),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .fwd_a         (fu_a),
        .fwd_b         (fu_b)
    );

    assign fwd_a = reset ? 2'b00 : fu_a;
    assign fwd_b = reset ? 2'b00 : fu_b;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed and randomized checks of hazard_ctrl against a cycle-count model
module tb_hazard_ctrl;
    import core_pkg::*;

    localparam int FILL  = 2;
    localparam int FLUSH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [4:0]  id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
    logic        id_use_rs1, id_use_rs2, ex_reg_write, mem_reg_write, wb_reg_write, mem_is_load;
    logic [6:0]  ex_opcode;
    logic [31:0] pc_if, alu_pc_new;
    logic        alu_pc_replace, alu_pc_JALR;
    logic        pc_replace_old, flag_old, redirect_valid, stall_pc, stall_if_id;
    logic        bubble_id_ex, flush_if_id;
    logic [31:0] redirect_pc;
    logic [1:0]  fwd_a, fwd_b;

    hazard_ctrl #(.FILL_CYCLES(FILL), .FLUSH_CYCLES(FLUSH)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_reg_write(ex_reg_write), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write), .mem_is_load(mem_is_load),
        .pc_if(pc_if), .alu_pc_replace(alu_pc_replace), .alu_pc_JALR(alu_pc_JALR),
        .alu_pc_new(alu_pc_new), .pc_replace_old(pc_replace_old), .flag_old(flag_old),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall_pc(stall_pc),
        .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex), .flush_if_id(flush_if_id),
        .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: cycles left of invalid EX after reset / after a redirect
    int fill_left  = FILL;
    int flush_left = 0;
    bit stalled_last  = 1'b0;
    bit prev_redirect = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
        if (mem_reg_write && mem_rd != 0 && !mem_is_load && mem_rd == rs) return 2'b01;
        if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 2'b10;
        return 2'b00;
    endfunction

    task automatic run_cycle();
        bit valid, redir, lu, stall, flush;
        logic [31:0] rpc;
        logic [1:0] fa, fb;
        #2;
        valid = !reset && fill_left == 0 && flush_left == 0;
        redir = valid && alu_pc_replace;
        rpc   = !redir ? 32'd0 : (alu_pc_JALR ? alu_pc_new : pc_if + alu_pc_new);
        lu    = ex_opcode == 7'b0000011 && ex_reg_write && ex_rd != 0 &&
                ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        stall = valid && !redir && !stalled_last && lu;
        flush = !reset && (flush_left > 0 || redir);
        fa    = reset ? 2'b00 : fwd_ref(ex_rs1);
        fb    = reset ? 2'b00 : fwd_ref(ex_rs2);
        check("flag_old",       32'(flag_old),       32'(valid));
        check("pc_replace_old", 32'(pc_replace_old), 32'(prev_redirect));
        check("redirect_valid", 32'(redirect_valid), 32'(redir));
        check("redirect_pc",    redirect_pc,         rpc);
        check("stall_pc",       32'(stall_pc),       32'(stall));
        check("stall_if_id",    32'(stall_if_id),    32'(stall));
        check("bubble_id_ex",   32'(bubble_id_ex),   32'(stall));
        check("flush_if_id",    32'(flush_if_id),    32'(flush));
        check("fwd_a",          32'(fwd_a),          32'(fa));
        check("fwd_b",          32'(fwd_b),          32'(fb));
        @(posedge clk);
        #1;
        if (reset) begin
            fill_left = FILL; flush_left = 0; stalled_last = 1'b0; prev_redirect = 1'b0;
        end else begin
            if (fill_left > 0)       fill_left--;
            else if (flush_left > 0) flush_left--;
            if (redir) flush_left = FLUSH;
            stalled_last  = stall;
            prev_redirect = redir;
        end
    endtask

    task automatic idle_inputs();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_opcode = 7'b0110011; ex_rd = 0; ex_rs1 = 0; ex_rs2 = 0; ex_reg_write = 0;
        mem_rd = 0; wb_rd = 0; mem_reg_write = 0; wb_reg_write = 0; mem_is_load = 0;
        pc_if = 0; alu_pc_replace = 0; alu_pc_JALR = 0; alu_pc_new = 0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        run_cycle();
        run_cycle();
        reset = 1'b0;
        repeat (4) run_cycle();

        pc_if = 32'h100; alu_pc_new = 32'h20; alu_pc_replace = 1;
        #1 check("redirect_pc_branch", redirect_pc, 32'h120);
        run_cycle();
        alu_pc_replace = 0;
        #1 check("flush_after_branch", 32'(flush_if_id), 32'd1);
        repeat (3) run_cycle();

        alu_pc_JALR = 1; alu_pc_new = 32'h8000_0004; alu_pc_replace = 1;
        #1 check("redirect_pc_jalr", redirect_pc, 32'h8000_0004);
        repeat (3) run_cycle();
        alu_pc_replace = 0; alu_pc_JALR = 0;
        repeat (2) run_cycle();

        ex_opcode = 7'b0000011; ex_reg_write = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
        #1 check("load_use_stall", 32'(stall_pc), 32'd1);
        repeat (2) run_cycle();
        ex_rd = 0;
        run_cycle();
        ex_rd = 5; alu_pc_replace = 1; pc_if = 32'h200; alu_pc_new = 32'hFFFF_FFF0;
        run_cycle();
        alu_pc_replace = 0;
        repeat (3) run_cycle();
        idle_inputs();

        ex_rs1 = 7; mem_rd = 7; wb_rd = 7; mem_reg_write = 1; wb_reg_write = 1;
        #1 check("fwd_mem_wins", 32'(fwd_a), 32'd1);
        run_cycle();
        mem_is_load = 1;
        run_cycle();
        ex_rs1 = 0;
        run_cycle();
        idle_inputs();

        alu_pc_replace = 1; pc_if = 32'h40; alu_pc_new = 32'h8;
        run_cycle();
        alu_pc_replace = 0;
        run_cycle();
        reset = 1;
        run_cycle();
        reset = 0;
        #1 check("reset_mid_flush", 32'(flush_if_id), 32'd0);
        repeat (3) run_cycle();

        for (int i = 0; i < 400; i++) begin
            reset          = ($urandom_range(0, 49) == 0);
            id_rs1         = 5'($urandom_range(0, 3));
            id_rs2         = 5'($urandom_range(0, 3));
            id_use_rs1     = 1'($urandom);
            id_use_rs2     = 1'($urandom);
            ex_opcode      = $urandom_range(0, 1) ? 7'b0000011 : 7'($urandom);
            ex_rd          = 5'($urandom_range(0, 3));
            ex_rs1         = 5'($urandom_range(0, 3));
            ex_rs2         = 5'($urandom_range(0, 3));
            ex_reg_write   = 1'($urandom);
            mem_rd         = 5'($urandom_range(0, 3));
            wb_rd          = 5'($urandom_range(0, 3));
            mem_reg_write  = 1'($urandom);
            wb_reg_write   = 1'($urandom);
            mem_is_load    = 1'($urandom);
            pc_if          = $urandom;
            alu_pc_new     = $urandom;
            alu_pc_JALR    = 1'($urandom);
            alu_pc_replace = ($urandom_range(0, 5) == 0);
            run_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
